reg_window_spill_fill: RTL and testbench

- Spill/fill engine that sits on the other side of the windowed 8x16 register file (4 windows × 2 registers, window base = 2×wnd mod 8).
- On spill, it reads both registers of a selected window through the register-file read/select port and pushes them onto a LIFO stack in data memory.
- On fill, it pops two words from that stack and writes them back into the selected window through the register-file write port.
- Used by the context-switch/call sequencer to free and restore windows.

---
 rtl/reg_window_spill_fill.sv | 151 +++++++++++++++
 tb/tb_reg_window_spill_fill.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_window_spill_fill.sv
// Register-window spill/fill engine: moves the two registers of one window
// to/from a word-wide LIFO stack in data memory.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   spill_req         save window wnd_in to the stack (sampled when idle)
//   fill_req          restore window wnd_in from the stack (sampled when idle)
//   wnd_in            target window
//   busy, done, err   status: not idle / completion pulse / full-empty pulse
//   sp                stack depth in words
//   rf_set_window     register file window select strobe
//   rf_wnd            register file window
//   rf_r_i            register index within the window
//   rf_rdata          register file combinational read data
//   rf_write          register file write strobe
//   rf_wdata          register file write data
//   mem_req, mem_we   memory request (held until mem_ack) and direction
//   mem_addr          BASE_ADDR + word index
//   mem_wdata         memory write data
//   mem_ack           completes the request in the cycle it is high
//   mem_rdata         memory read data, valid with mem_ack
module reg_window_spill_fill #(
   parameter int            DEPTH     = 8,
   parameter int            AW        = 16,
   parameter logic [AW-1:0] BASE_ADDR = '0,
   localparam int           SPW       = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           spill_req,
   input  logic           fill_req,
   input  logic [1:0]     wnd_in,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [SPW-1:0] sp,
   output logic           rf_set_window,
   output logic [1:0]     rf_wnd,
   output logic [1:0]     rf_r_i,
   input  logic [15:0]    rf_rdata,
   output logic           rf_write,
   output logic [15:0]    rf_wdata,
   output logic           mem_req,
   output logic           mem_we,
   output logic [AW-1:0]  mem_addr,
   output logic [15:0]    mem_wdata,
   input  logic           mem_ack,
   input  logic [15:0]    mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, SEL, SP_RD, SP_WR, FL_RD, FL_WR, DONE
   } state_t;

   localparam logic [SPW-1:0] FULL_LIM = SPW'(DEPTH - 2);
   localparam logic [SPW-1:0] TWO      = SPW'(2);

   state_t      state;
   logic        k;
   logic [1:0]  w;
   logic [15:0] hold;
   logic        err_q;

   // k doubles as the operation tag in SEL: 0 = spill, 1 = fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sp    <= '0;
         k     <= 1'b0;
         w     <= '0;
         hold  <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (spill_req) begin
                  if (sp > FULL_LIM) begin
                     err_q <= 1'b1;
                  end else begin
                     state <= SEL;
                     w     <= wnd_in;
                     k     <= 1'b0;
                  end
               end else if (fill_req) begin
                  if (sp < TWO) begin
                     err_q <= 1'b1;
                  end else begin
                     state <= SEL;
                     w     <= wnd_in;
                     k     <= 1'b1;
                  end
               end
            end
            SEL: state <= k ? FL_RD : SP_RD;
            SP_RD: begin
               hold  <= rf_rdata;
               state <= SP_WR;
            end
            SP_WR: begin
               if (mem_ack) begin
                  sp <= sp + 1'b1;
                  if (!k) begin
                     k     <= 1'b1;
                     state <= SP_RD;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            FL_RD: begin
               if (mem_ack) begin
                  hold  <= mem_rdata;
                  sp    <= sp - 1'b1;
                  state <= FL_WR;
               end
            end
            FL_WR: begin
               if (k) begin
                  k     <= 1'b0;
                  state <= FL_RD;
               end else begin
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic [AW-1:0] top_addr;
   assign top_addr = BASE_ADDR + AW'(sp);

   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign err           = err_q;
   assign rf_set_window = (state == SEL);
   assign rf_wnd        = busy ? w : 2'b00;
   assign rf_r_i        = (state == SP_RD || state == FL_WR)
                          ? {1'b0, k} : 2'b00;
   assign rf_write      = (state == FL_WR);
   assign rf_wdata      = (state == FL_WR) ? hold : 16'h0000;
   assign mem_req       = (state == SP_WR || state == FL_RD);
   assign mem_we        = (state == SP_WR);
   // Pop reads the topmost word, one below the stack pointer.
   assign mem_addr      = (state == SP_WR) ? top_addr :
                          (state == FL_RD) ? top_addr - 1'b1 : '0;
   assign mem_wdata     = (state == SP_WR) ? hold : 16'h0000;

endmodule

// File: tb/tb_reg_window_spill_fill.sv
// Directed bench for reg_window_spill_fill with register-file
// and wait-state memory models.
module tb_reg_window_spill_fill;

   localparam logic [15:0] BASE = 16'h0040;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spill_req = 1'b0;
   logic        fill_req = 1'b0;
   logic [1:0]  wnd_in = 2'd0;
   logic        busy, done, err;
   logic [3:0]  sp;
   logic        rf_set_window;
   logic [1:0]  rf_wnd, rf_r_i;
   logic [15:0] rf_rdata;
   logic        rf_write;
   logic [15:0] rf_wdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   reg_window_spill_fill #(
      .DEPTH(8), .AW(16), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst),
      .spill_req(spill_req), .fill_req(fill_req), .wnd_in(wnd_in),
      .busy(busy), .done(done), .err(err), .sp(sp),
      .rf_set_window(rf_set_window), .rf_wnd(rf_wnd),
      .rf_r_i(rf_r_i), .rf_rdata(rf_rdata),
      .rf_write(rf_write), .rf_wdata(rf_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // register file model: 4 windows x 2 regs, window latched on setWindow
   logic [15:0] rf [0:7];
   logic [1:0]  cur_w = 2'd0;
   logic [2:0]  ridx;
   logic        poke = 1'b0;
   logic [2:0]  poke_i = 3'd0;
   logic [15:0] poke_v = 16'h0;
   int          nrfw = 0;
   logic [2:0]  rfw_idx [0:63];

   assign ridx     = 3'(int'(cur_w) * 2 + int'(rf_r_i));
   assign rf_rdata = rf[ridx];

   // memory model with programmable wait states
   logic [15:0] mem [0:15];
   int          wait_n = 0;
   int          wcnt = 0;
   logic [3:0]  midx;
   int          nwr = 0;
   logic [15:0] wr_addr [0:63];
   logic [15:0] wr_data [0:63];
   int          ndone = 0;
   bit          stab_chk = 1'b0;
   bit          pend = 1'b0;
   logic [15:0] p_addr = 16'h0;
   logic [15:0] p_wdata = 16'h0;

   assign midx      = 4'(mem_addr - BASE);
   assign mem_ack   = mem_req && (wcnt >= wait_n);
   assign mem_rdata = mem[midx];

   always @(posedge clk) begin
      if (poke) rf[poke_i] <= poke_v;
      if (rf_set_window) cur_w <= rf_wnd;
      if (rf_write) begin
         rf[ridx] <= rf_wdata;
         rfw_idx[nrfw] <= ridx;
         nrfw <= nrfw + 1;
      end
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_req && mem_ack && mem_we) begin
         mem[midx] <= mem_wdata;
         wr_addr[nwr] <= mem_addr;
         wr_data[nwr] <= mem_wdata;
         nwr <= nwr + 1;
      end
      if (done) ndone <= ndone + 1;
      if (stab_chk && pend) begin
         chk("wait_req", {31'd0, mem_req}, 32'd1);
         chk("wait_addr", {16'd0, mem_addr}, {16'd0, p_addr});
         chk("wait_wdata", {16'd0, mem_wdata}, {16'd0, p_wdata});
      end
      pend    <= mem_req && !mem_ack;
      p_addr  <= mem_addr;
      p_wdata <= mem_wdata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rf_set(input logic [2:0] i, input logic [15:0] v);
      poke_i = i;
      poke_v = v;
      poke = 1'b1;
      step();
      poke = 1'b0;
   endtask

   task automatic run(input bit s, input bit f, input logic [1:0] w,
                      output int lat);
      spill_req = s;
      fill_req = f;
      wnd_in = w;
      step();
      spill_req = 1'b0;
      fill_req = 1'b0;
      lat = 1;
      while (!done && lat < 60) begin
         step();
         lat++;
      end
   endtask

   int lat;
   int d0;

   initial begin
      rst = 1'b1;
      step();
      step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_sp", {28'd0, sp}, 32'd0);
      chk("rst_mreq", {31'd0, mem_req}, 32'd0);
      chk("rst_rfw", {31'd0, rf_write}, 32'd0);
      rst = 1'b0;
      step();

      // spill window 1
      rf_set(3'd2, 16'hA5A5);
      rf_set(3'd3, 16'h1234);
      run(1'b1, 1'b0, 2'd1, lat);
      chk("sp1_lat", lat, 32'd6);
      chk("sp1_sp", {28'd0, sp}, 32'd2);
      chk("sp1_nwr", nwr, 32'd2);
      chk("sp1_a0", {16'd0, wr_addr[0]}, 32'h40);
      chk("sp1_d0", {16'd0, wr_data[0]}, 32'hA5A5);
      chk("sp1_a1", {16'd0, wr_addr[1]}, 32'h41);
      chk("sp1_d1", {16'd0, wr_data[1]}, 32'h1234);
      chk("sp1_rfw", nrfw, 32'd0);
      step();
      chk("sp1_idle", {31'd0, busy}, 32'd0);

      // fill window 1 back after clearing
      rf_set(3'd2, 16'h0000);
      rf_set(3'd3, 16'h0000);
      run(1'b0, 1'b1, 2'd1, lat);
      chk("fl1_lat", lat, 32'd6);
      chk("fl1_sp", {28'd0, sp}, 32'd0);
      step();
      chk("fl1_r0", {16'd0, rf[2]}, 32'hA5A5);
      chk("fl1_r1", {16'd0, rf[3]}, 32'h1234);
      chk("fl1_nrfw", nrfw, 32'd2);
      chk("fl1_first", {29'd0, rfw_idx[0]}, 32'd3);
      chk("fl1_second", {29'd0, rfw_idx[1]}, 32'd2);
      chk("fl1_nwr", nwr, 32'd2);

      // fill when empty
      fill_req = 1'b1;
      wnd_in = 2'd1;
      step();
      fill_req = 1'b0;
      chk("emp_err", {31'd0, err}, 32'd1);
      chk("emp_busy", {31'd0, busy}, 32'd0);
      chk("emp_mreq", {31'd0, mem_req}, 32'd0);
      step();
      chk("emp_err_off", {31'd0, err}, 32'd0);
      chk("emp_sp", {28'd0, sp}, 32'd0);

      // spill with 3 wait states per access
      rf_set(3'd4, 16'hBEEF);
      rf_set(3'd5, 16'hCAFE);
      wait_n = 3;
      stab_chk = 1'b1;
      run(1'b1, 1'b0, 2'd2, lat);
      stab_chk = 1'b0;
      wait_n = 0;
      chk("ws_lat", lat, 32'd12);
      chk("ws_sp", {28'd0, sp}, 32'd2);
      chk("ws_a0", {16'd0, wr_addr[2]}, 32'h40);
      chk("ws_d0", {16'd0, wr_data[2]}, 32'hBEEF);
      chk("ws_a1", {16'd0, wr_addr[3]}, 32'h41);
      chk("ws_d1", {16'd0, wr_data[3]}, 32'hCAFE);
      step();

      // simultaneous spill and fill: spill wins
      rf_set(3'd6, 16'h1111);
      rf_set(3'd7, 16'h2222);
      run(1'b1, 1'b1, 2'd3, lat);
      chk("both_lat", lat, 32'd6);
      chk("both_sp", {28'd0, sp}, 32'd4);
      chk("both_a0", {16'd0, wr_addr[4]}, 32'h42);
      chk("both_d1", {16'd0, wr_data[5]}, 32'h2222);
      chk("both_rfw", nrfw, 32'd2);
      step();

      // fill pulsed while busy is ignored
      rf_set(3'd0, 16'h0A0A);
      rf_set(3'd1, 16'h0B0B);
      d0 = ndone;
      spill_req = 1'b1;
      wnd_in = 2'd0;
      step();
      spill_req = 1'b0;
      step();
      fill_req = 1'b1;
      step();
      fill_req = 1'b0;
      repeat (8) step();
      chk("busy_done", ndone - d0, 32'd1);
      chk("busy_sp", {28'd0, sp}, 32'd6);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("busy_d0", {16'd0, wr_data[6]}, 32'h0A0A);
      chk("busy_a1", {16'd0, wr_addr[7]}, 32'h45);

      // fill up the stack
      run(1'b1, 1'b0, 2'd1, lat);
      chk("full_lat", lat, 32'd6);
      chk("full_sp", {28'd0, sp}, 32'd8);
      step();

      // spill when full
      spill_req = 1'b1;
      wnd_in = 2'd2;
      step();
      spill_req = 1'b0;
      chk("full_err", {31'd0, err}, 32'd1);
      chk("full_busy", {31'd0, busy}, 32'd0);
      step();
      chk("full_sp2", {28'd0, sp}, 32'd8);
      chk("full_nwr", nwr, 32'd10);
      chk("full_err_off", {31'd0, err}, 32'd0);

      // pop top pair into window 3
      run(1'b0, 1'b1, 2'd3, lat);
      chk("fl3_lat", lat, 32'd6);
      chk("fl3_sp", {28'd0, sp}, 32'd6);
      step();
      chk("fl3_r1", {16'd0, rf[7]}, 32'h1234);
      chk("fl3_r0", {16'd0, rf[6]}, 32'hA5A5);

      // reset while waiting on memory in SP_WR
      wait_n = 20;
      spill_req = 1'b1;
      wnd_in = 2'd0;
      step();
      spill_req = 1'b0;
      step();
      step();
      chk("mr_mreq", {31'd0, mem_req}, 32'd1);
      chk("mr_we", {31'd0, mem_we}, 32'd1);
      chk("mr_addr", {16'd0, mem_addr}, 32'h46);
      chk("mr_wdata", {16'd0, mem_wdata}, 32'h0A0A);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_n = 0;
      chk("mr_mreq0", {31'd0, mem_req}, 32'd0);
      chk("mr_busy0", {31'd0, busy}, 32'd0);
      chk("mr_sp0", {28'd0, sp}, 32'd0);
      chk("mr_nwr", nwr, 32'd10);
      run(1'b1, 1'b0, 2'd0, lat);
      chk("mr_lat", lat, 32'd6);
      chk("mr_a0", {16'd0, wr_addr[10]}, 32'h40);
      chk("mr_d0", {16'd0, wr_data[10]}, 32'h0A0A);
      chk("mr_sp2", {28'd0, sp}, 32'd2);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
